// File: rtl/dispatch_queue_if.sv
// Issue-side handshake bundle for dispatch_queue: decoded micro-op input and FU issue ports.
// Member suffixes are from the queue's point of view (slave modport).
interface dispatch_queue_if #(
   parameter int unsigned DATA_W = 96,
   parameter int unsigned NUM_FU = 6,
   parameter int unsigned GRP_W  = 3
);
   logic              in_valid_i;
   logic              in_ready_o;
   logic [GRP_W-1:0]  in_grp_i;
   logic [DATA_W-1:0] in_payload_i;
   logic [NUM_FU-1:0] fu_valid_o;
   logic [NUM_FU-1:0] fu_ready_i;
   logic [DATA_W-1:0] fu_payload_o;

   modport slave (
      input  in_valid_i, in_grp_i, in_payload_i, fu_ready_i,
      output in_ready_o, fu_valid_o, fu_payload_o
   );

   modport master (
      output in_valid_i, in_grp_i, in_payload_i, fu_ready_i,
      input  in_ready_o, fu_valid_o, fu_payload_o
   );
endinterface

// File: rtl/dispatch_queue.sv
// In-order micro-op dispatch queue with one-hot FU issue and illegal-group drop.
// Optional same-cycle bypass into an empty queue when DISPATCH_BYPASS_EN is defined.
module dispatch_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 96,
   parameter int unsigned NUM_FU = 6,
   parameter int unsigned GRP_W  = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   dispatch_queue_if.slave          bus,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic                     illegal_grp_o,
   output logic [15:0]              stall_cnt_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [GRP_W-1:0]  grp_mem  [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];

   logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [15:0]   stall_q, stall_d;

   logic [NUM_FU-1:0] head_oh;
   logic              head_legal, queue_issue, illegal_drop;
   logic              empty, full, push, pop, issue_fire, bypass;

   // Group g maps to bit g-1; anything outside 1..NUM_FU decodes to zero (illegal).
   function automatic logic [NUM_FU-1:0] grp_dec(input logic [GRP_W-1:0] g);
      logic [NUM_FU-1:0] dec;
      dec = '0;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         if (g == GRP_W'(i + 1)) dec[i] = 1'b1;
      end
      return dec;
   endfunction

   assign empty        = (cnt_q == '0);
   assign full         = (cnt_q == (AW+1)'(DEPTH));
   assign head_oh      = grp_dec(grp_mem[rptr_q]);
   assign head_legal   = |head_oh;
   assign queue_issue  = ~empty & ~flush_i & head_legal;
   assign illegal_drop = ~empty & ~flush_i & ~head_legal;

`ifdef DISPATCH_BYPASS_EN
   logic [NUM_FU-1:0] in_oh;
   assign in_oh  = grp_dec(bus.in_grp_i);
   assign bypass = ~rst & bus.in_valid_i & empty & ~flush_i & (|(in_oh & bus.fu_ready_i));
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      bus.fu_valid_o   = '0;
      bus.fu_payload_o = '0;
      if (queue_issue) begin
         bus.fu_valid_o   = head_oh;
         bus.fu_payload_o = data_mem[rptr_q];
      end
`ifdef DISPATCH_BYPASS_EN
      else if (bypass) begin
         bus.fu_valid_o   = in_oh;
         bus.fu_payload_o = bus.in_payload_i;
      end
`endif
   end

   assign issue_fire = |(bus.fu_valid_o & bus.fu_ready_i);
   assign pop        = (queue_issue & (|(head_oh & bus.fu_ready_i))) | illegal_drop;
   // A pop in a full cycle never frees a slot for the same-cycle push.
   assign push       = bus.in_valid_i & ~full & ~flush_i & ~bypass;

   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      cnt_d   = cnt_q;
      stall_d = stall_q;
      if (flush_i) begin
         rptr_d = '0;
         wptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) wptr_d = wptr_q + 1'b1;
         if (pop)  rptr_d = rptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
      if ((|bus.fu_valid_o) && !issue_fire && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         cnt_q   <= '0;
         stall_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
      end
   end

   // Storage is unreset; occupancy gating keeps stale entries off the outputs.
   always_ff @(posedge clk) begin
      if (push) begin
         grp_mem[wptr_q]  <= bus.in_grp_i;
         data_mem[wptr_q] <= bus.in_payload_i;
      end
   end

   assign bus.in_ready_o = ~full;
   assign count_o        = cnt_q;
   assign empty_o        = empty;
   assign full_o         = full;
   assign illegal_grp_o  = illegal_drop;
   assign stall_cnt_o    = stall_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed self-checking bench for dispatch_queue (default parameters).
module tb_dispatch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [2:0]  count;
   logic        empty, full, illegal;
   logic [15:0] stall;
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   dispatch_queue_if #(.DATA_W(96), .NUM_FU(6), .GRP_W(3)) bus ();

   dispatch_queue #(.DEPTH(4), .DATA_W(96), .NUM_FU(6), .GRP_W(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush_i       (flush),
      .bus           (bus),
      .count_o       (count),
      .empty_o       (empty),
      .full_o        (full),
      .illegal_grp_o (illegal),
      .stall_cnt_o   (stall)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] g, input logic [95:0] p);
      bus.in_valid_i   = v;
      bus.in_grp_i     = g;
      bus.in_payload_i = p;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".count"},   count, 0);
      check({tag, ".empty"},   empty, 1);
      check({tag, ".full"},    full, 0);
      check({tag, ".ready"},   bus.in_ready_o, 1);
      check({tag, ".fuvalid"}, bus.fu_valid_o, 0);
      check({tag, ".payload"}, bus.fu_payload_o, 0);
      check({tag, ".illegal"}, illegal, 0);
      check({tag, ".stall"},   stall, 0);
   endtask

   initial begin
      drive(1'b0, 3'd0, 96'h0);
      bus.fu_ready_i = '0;
      #2;
      check_reset_state("rst");
      step();
      rst = 1'b0;

      // Basic issue of grp=3
      bus.fu_ready_i = '1;
      drive(1'b1, 3'd3, 96'hA5);
      #1;
`ifdef DISPATCH_BYPASS_EN
      check("g3.byp_valid", bus.fu_valid_o, 6'b000100);
      check("g3.byp_data",  bus.fu_payload_o, 96'hA5);
      step();
      drive(1'b0, 3'd0, 96'h0);
      #1;
      check("g3.count", count, 0);
`else
      check("g3.no_early", bus.fu_valid_o, 0);
      step();
      drive(1'b0, 3'd0, 96'h0);
      #1;
      check("g3.count1", count, 1);
      check("g3.valid",  bus.fu_valid_o, 6'b000100);
      check("g3.data",   bus.fu_payload_o, 96'hA5);
      step();
      check("g3.empty", empty, 1);
      check("g3.count0", count, 0);
`endif

      // Fill with grp=1 while blocked
      bus.fu_ready_i = '0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 3'd1, 96'h100 + 96'(i));
         step();
      end
      drive(1'b1, 3'd1, 96'h1FF);
      #1;
      check("fill.full",  full, 1);
      check("fill.ready", bus.in_ready_o, 0);
      check("fill.count", count, 4);
      check("fill.stall", stall, 3);
      step();
      check("fill.count_hold", count, 4);
      check("fill.stall4", stall, 4);
      bus.fu_ready_i = 6'b111110;
      step();
      check("fill.other_ready", count, 4);
      check("fill.stall5", stall, 5);
      bus.fu_ready_i = '1;
      #1;
      check("fill.ready_on_pop", bus.in_ready_o, 0);
      check("fill.order0", bus.fu_payload_o, 96'h100);
      step();
      drive(1'b0, 3'd0, 96'h0);
      #1;
      check("fill.count3", count, 3);
      for (int i = 1; i < 4; i++) begin
         check("fill.order", bus.fu_payload_o, 96'h100 + 96'(i));
         step();
      end
      check("fill.drained", empty, 1);
      check("fill.stall_keep", stall, 5);

      // Illegal group dropped, next legal entry issues
      drive(1'b1, 3'd0, 96'h11);
      step();
      drive(1'b1, 3'd2, 96'h22);
      #1;
      check("ill.pulse", illegal, 1);
      check("ill.noissue", bus.fu_valid_o, 0);
      step();
      drive(1'b0, 3'd0, 96'h0);
      #1;
      check("ill.pulse_end", illegal, 0);
      check("ill.count", count, 1);
      check("ill.g2valid", bus.fu_valid_o, 6'b000010);
      check("ill.g2data", bus.fu_payload_o, 96'h22);
      step();
      check("ill.empty", empty, 1);
      check("ill.quiet", illegal, 0);

      // Flush with three queued and a concurrent push
      bus.fu_ready_i = '0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 3'd2, 96'h30 + 96'(i));
         step();
      end
      check("fl.count3", count, 3);
      drive(1'b1, 3'd2, 96'h3F);
      flush = 1'b1;
      #1;
      check("fl.valid_masked", bus.fu_valid_o, 0);
      step();
      flush = 1'b0;
      drive(1'b0, 3'd0, 96'h0);
      #1;
      check("fl.count", count, 0);
      check("fl.empty", empty, 1);
      check("fl.valid", bus.fu_valid_o, 0);
      check("fl.stall", stall, 7);

      // grp=5 into empty queue with only FU4 ready
      bus.fu_ready_i = 6'b010000;
      drive(1'b1, 3'd5, 96'h55);
      #1;
`ifdef DISPATCH_BYPASS_EN
      check("g5.byp_valid", bus.fu_valid_o, 6'b010000);
      check("g5.byp_data",  bus.fu_payload_o, 96'h55);
      step();
      drive(1'b0, 3'd0, 96'h0);
      #1;
      check("g5.count", count, 0);
`else
      check("g5.no_early", bus.fu_valid_o, 0);
      step();
      drive(1'b0, 3'd0, 96'h0);
      #1;
      check("g5.count1", count, 1);
      check("g5.valid",  bus.fu_valid_o, 6'b010000);
      check("g5.data",   bus.fu_payload_o, 96'h55);
      step();
      check("g5.empty", empty, 1);
`endif

      // Asynchronous reset while two entries are queued
      bus.fu_ready_i = '0;
      drive(1'b1, 3'd4, 96'h41);
      step();
      drive(1'b1, 3'd4, 96'h42);
      step();
      drive(1'b0, 3'd0, 96'h0);
      #1;
      check("ar.count", count, 2);
      check("ar.valid", bus.fu_valid_o, 6'b001000);
      check("ar.stall", stall, 8);
      #1;
      rst = 1'b1;
      #1;
      check_reset_state("ar");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
